// File: rtl/shift_operand_seq_if.sv
// Operand-2 request/result bundle plus the shiftee mux select encodings shared with the mux.
// slave = sequencer side, master = requester/consumer side.
`ifndef IMMED_8_SEL
`define IMMED_8_SEL  2'd0
`endif
`ifndef RM_SEL
`define RM_SEL       2'd1
`endif
`ifndef IMMED_32_SEL
`define IMMED_32_SEL 2'd2
`endif

interface shift_operand_seq_if #(
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        op_kind;
    logic [1:0]        shift_type;
    logic [4:0]        shift_imm;
    logic [3:0]        rotate_imm;
    logic [3:0]        rs_idx;
    logic              carry_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] operand;
    logic              carry_out;

    modport slave (
        input  req_valid, op_kind, shift_type, shift_imm, rotate_imm, rs_idx, carry_in, out_ready,
        output req_ready, out_valid, operand, carry_out
    );

    modport master (
        output req_valid, op_kind, shift_type, shift_imm, rotate_imm, rs_idx, carry_in, out_ready,
        input  req_ready, out_valid, operand, carry_out
    );
endinterface

// File: rtl/shift_operand_seq.sv
// Operand-2 sequencer: selects shiftee, optionally fetches Rs, applies ARM shift/rotate.
// Result valid 2 cycles after accept (3 with Rs fetch); result held until out_ready, one request in flight.
module shift_operand_seq #(
    parameter int DATA_W = 32,
    parameter int RS_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    shift_operand_seq_if.slave bus,
    output logic [1:0]        shiftee_sel,
    input  logic [DATA_W-1:0] shiftee,
    output logic              rs_rd_en,
    output logic [3:0]        rs_addr,
    input  logic [DATA_W-1:0] rs_data
);

    typedef enum logic [1:0] {IDLE, RS_READ, EXEC, DONE} state_t;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    state_t      state;
    logic        req_ready_q;
    logic        out_valid_q;
    logic [31:0] operand_q;
    logic        carry_q;
    logic [1:0]  kind_q;
    logic [1:0]  type_q;
    logic [4:0]  simm_q;
    logic [3:0]  rot_q;
    logic        cin_q;

    logic [31:0] imm8_val;
    logic [7:0]  rs_amt;
    logic [32:0] nz_imm;
    logic [32:0] nz_reg;
    logic [31:0] res_c;
    logic        carry_c;

    // Only rs_data[7:0] matters; parameters are fixed at 32 / 1.
    logic unused_ok;
    assign unused_ok = ^rs_data[DATA_W-1:8] ^ ((RS_LAT == 1) && (DATA_W == 32));

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    endfunction

    // Shift by a non-zero amount below 32; returns {carry, result}.
    function automatic logic [32:0] shift_nz(input logic [1:0] typ, input logic [4:0] n,
                                             input logic [31:0] rm);
        logic [32:0] t;
        logic [31:0] r;
        t = 33'd0;
        r = 32'd0;
        case (typ)
            SH_LSL: begin
                t = {1'b0, rm} << n;
                return {t[32], t[31:0]};
            end
            SH_LSR: begin
                t = {rm, 1'b0} >> n;
                return {t[0], t[32:1]};
            end
            SH_ASR: begin
                t = $unsigned($signed({rm, 1'b0}) >>> n);
                return {t[0], t[32:1]};
            end
            default: begin
                r = ror32(rm, n);
                return {r[31], r};
            end
        endcase
    endfunction

    // The mux sign-extends imm8; only the low byte is meaningful.
    assign imm8_val = {24'd0, shiftee[7:0]};
    assign rs_amt   = rs_data[7:0];
    assign nz_imm   = shift_nz(type_q, simm_q, shiftee);
    assign nz_reg   = shift_nz(type_q, rs_amt[4:0], shiftee);

    always_comb begin
        res_c   = shiftee;
        carry_c = cin_q;
        case (kind_q)
            2'd0: begin
                res_c   = ror32(imm8_val, {rot_q, 1'b0});
                carry_c = (rot_q == 4'd0) ? cin_q : res_c[31];
            end
            2'd1: begin
                if (simm_q != 5'd0) begin
                    {carry_c, res_c} = nz_imm;
                end else begin
                    case (type_q)
                        SH_LSL: ;
                        SH_LSR: begin
                            res_c   = 32'd0;
                            carry_c = shiftee[31];
                        end
                        SH_ASR: begin
                            res_c   = {32{shiftee[31]}};
                            carry_c = shiftee[31];
                        end
                        default: begin
                            res_c   = {cin_q, shiftee[31:1]};
                            carry_c = shiftee[0];
                        end
                    endcase
                end
            end
            2'd2: begin
                if (rs_amt != 8'd0) begin
                    case (type_q)
                        SH_LSL: begin
                            if (rs_amt < 8'd32) begin
                                {carry_c, res_c} = nz_reg;
                            end else begin
                                res_c   = 32'd0;
                                carry_c = (rs_amt == 8'd32) ? shiftee[0] : 1'b0;
                            end
                        end
                        SH_LSR: begin
                            if (rs_amt < 8'd32) begin
                                {carry_c, res_c} = nz_reg;
                            end else begin
                                res_c   = 32'd0;
                                carry_c = (rs_amt == 8'd32) ? shiftee[31] : 1'b0;
                            end
                        end
                        SH_ASR: begin
                            if (rs_amt < 8'd32) begin
                                {carry_c, res_c} = nz_reg;
                            end else begin
                                res_c   = {32{shiftee[31]}};
                                carry_c = shiftee[31];
                            end
                        end
                        default: begin
                            if (rs_amt[4:0] == 5'd0) begin
                                carry_c = shiftee[31];
                            end else begin
                                {carry_c, res_c} = nz_reg;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            rs_rd_en    <= 1'b0;
            rs_addr     <= 4'd0;
            shiftee_sel <= `RM_SEL;
            operand_q   <= 32'd0;
            carry_q     <= 1'b0;
            kind_q      <= 2'd0;
            type_q      <= 2'd0;
            simm_q      <= 5'd0;
            rot_q       <= 4'd0;
            cin_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        kind_q      <= bus.op_kind;
                        type_q      <= bus.shift_type;
                        simm_q      <= bus.shift_imm;
                        rot_q       <= bus.rotate_imm;
                        cin_q       <= bus.carry_in;
                        rs_addr     <= bus.rs_idx;
                        req_ready_q <= 1'b0;
                        case (bus.op_kind)
                            2'd0:    shiftee_sel <= `IMMED_8_SEL;
                            2'd3:    shiftee_sel <= `IMMED_32_SEL;
                            default: shiftee_sel <= `RM_SEL;
                        endcase
                        if (bus.op_kind == 2'd2) begin
                            rs_rd_en <= 1'b1;
                            state    <= RS_READ;
                        end else begin
                            state    <= EXEC;
                        end
                    end
                end
                RS_READ: begin
                    rs_rd_en <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: begin
                    operand_q   <= res_c;
                    carry_q     <= carry_c;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.operand   = operand_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_shift_operand_seq.sv
// Directed bench for shift_operand_seq with a shiftee mux model and a one-cycle Rs register file.
`timescale 1ns/1ps
`ifndef IMMED_8_SEL
`define IMMED_8_SEL  2'd0
`endif
`ifndef RM_SEL
`define RM_SEL       2'd1
`endif
`ifndef IMMED_32_SEL
`define IMMED_32_SEL 2'd2
`endif

module tb_shift_operand_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  shiftee_sel;
    logic [31:0] shiftee;
    logic        rs_rd_en;
    logic [3:0]  rs_addr;
    logic [31:0] rs_data;

    logic [7:0]  imm8;
    logic [31:0] rm;
    logic [31:0] imm32;
    logic [31:0] regfile [16];
    logic        rs_rd_q = 1'b0;
    logic [3:0]  rs_addr_q = 4'd0;

    int checks   = 0;
    int failures = 0;

    shift_operand_seq_if #(.DATA_W(32)) bus ();

    shift_operand_seq #(.DATA_W(32), .RS_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .shiftee_sel (shiftee_sel),
        .shiftee     (shiftee),
        .rs_rd_en    (rs_rd_en),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data)
    );

    always #5 clk = ~clk;

    // External shiftee mux: imm8 is sign-extended on purpose.
    always_comb begin
        case (shiftee_sel)
            `IMMED_8_SEL:  shiftee = {{24{imm8[7]}}, imm8};
            `RM_SEL:       shiftee = rm;
            `IMMED_32_SEL: shiftee = imm32;
            default:       shiftee = 32'h0BAD_0BAD;
        endcase
    end

    // Register file answers one cycle after the strobe; all-ones otherwise.
    always @(posedge clk) begin
        rs_rd_q   <= rs_rd_en;
        rs_addr_q <= rs_addr;
    end
    assign rs_data = rs_rd_q ? regfile[rs_addr_q] : 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] kind, input logic [1:0] typ,
                          input logic [4:0] simm, input logic [3:0] rot, input logic [3:0] idx,
                          input logic cin, input logic [7:0] i8, input logic [31:0] r,
                          input logic [31:0] i32, input logic [31:0] rsv, input int hold,
                          input int exp_lat, input logic [1:0] exp_sel,
                          input logic [31:0] exp_op, input logic exp_c);
        int lat;
        int pulses;
        regfile[idx] = rsv;
        imm8  = i8;
        rm    = r;
        imm32 = i32;
        check({tag, ".ready_in"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.op_kind    = kind;
        bus.shift_type = typ;
        bus.shift_imm  = simm;
        bus.rotate_imm = rot;
        bus.rs_idx     = idx;
        bus.carry_in   = cin;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat    = 1;
        pulses = 0;
        while (!bus.out_valid && lat < 10) begin
            if (rs_rd_en) begin
                pulses++;
                check({tag, ".rs_addr"}, {28'd0, rs_addr}, {28'd0, idx});
            end
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rs_pulses"}, pulses, (kind == 2'd2) ? 1 : 0);
        check({tag, ".sel"}, {30'd0, shiftee_sel}, {30'd0, exp_sel});
        check({tag, ".operand"}, bus.operand, exp_op);
        check({tag, ".carry"}, {31'd0, bus.carry_out}, {31'd0, exp_c});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
            check({tag, ".hold_op"}, bus.operand, exp_op);
            check({tag, ".hold_sel"}, {30'd0, shiftee_sel}, {30'd0, exp_sel});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".ready_back"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) regfile[i] = 32'h0000_0100 + i;
        imm8 = 8'd0; rm = 32'd0; imm32 = 32'd0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.op_kind = 2'd0; bus.shift_type = 2'd0; bus.shift_imm = 5'd0;
        bus.rotate_imm = 4'd0; bus.rs_idx = 4'd0; bus.carry_in = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.rs_rd_en", {31'd0, rs_rd_en}, 32'd0);
        check("rst.rs_addr", {28'd0, rs_addr}, 32'd0);
        check("rst.sel", {30'd0, shiftee_sel}, {30'd0, `RM_SEL});
        check("rst.operand", bus.operand, 32'd0);
        check("rst.carry", {31'd0, bus.carry_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //     tag        kind  typ   simm  rot   idx   cin   imm8   rm            imm32         rs            hold lat sel            operand       c
        run_op("imm8_rot", 2'd0, 2'd0, 5'd0, 4'd4, 4'd0, 1'b0, 8'hFF, 32'h0,        32'h0,        32'h0,        0,   2, `IMMED_8_SEL,  32'hFF000000, 1'b1);
        run_op("imm8_r0",  2'd0, 2'd0, 5'd0, 4'd0, 4'd0, 1'b1, 8'h81, 32'h0,        32'h0,        32'h0,        0,   2, `IMMED_8_SEL,  32'h00000081, 1'b1);
        run_op("lsr0",     2'd1, 2'd1, 5'd0, 4'd0, 4'd0, 1'b1, 8'h00, 32'h80000001, 32'h0,        32'h0,        0,   2, `RM_SEL,       32'h00000000, 1'b1);
        run_op("rrx",      2'd1, 2'd3, 5'd0, 4'd0, 4'd0, 1'b1, 8'h00, 32'h80000001, 32'h0,        32'h0,        0,   2, `RM_SEL,       32'hC0000000, 1'b1);
        run_op("asr1",     2'd1, 2'd2, 5'd1, 4'd0, 4'd0, 1'b1, 8'h00, 32'h80000001, 32'h0,        32'h0,        0,   2, `RM_SEL,       32'hC0000000, 1'b1);
        run_op("lsl4",     2'd1, 2'd0, 5'd4, 4'd0, 4'd0, 1'b0, 8'h00, 32'h12345678, 32'h0,        32'h0,        0,   2, `RM_SEL,       32'h23456780, 1'b1);
        run_op("lsl0",     2'd1, 2'd0, 5'd0, 4'd0, 4'd0, 1'b0, 8'h00, 32'hF0000000, 32'h0,        32'h0,        0,   2, `RM_SEL,       32'hF0000000, 1'b0);
        run_op("rs_lsl32", 2'd2, 2'd0, 5'd0, 4'd0, 4'd5, 1'b0, 8'h00, 32'h00000003, 32'h0,        32'h00000120, 0,   3, `RM_SEL,       32'h00000000, 1'b1);
        run_op("rs_lsl33", 2'd2, 2'd0, 5'd0, 4'd0, 4'd6, 1'b1, 8'h00, 32'h00000003, 32'h0,        32'h00000021, 0,   3, `RM_SEL,       32'h00000000, 1'b0);
        run_op("rs_ror32", 2'd2, 2'd3, 5'd0, 4'd0, 4'd7, 1'b0, 8'h00, 32'h80000000, 32'h0,        32'h00000020, 0,   3, `RM_SEL,       32'h80000000, 1'b1);
        run_op("rs_lsr4",  2'd2, 2'd1, 5'd0, 4'd0, 4'd9, 1'b0, 8'h00, 32'h000000F8, 32'h0,        32'h00000004, 0,   3, `RM_SEL,       32'h0000000F, 1'b1);
        run_op("rs_asr40", 2'd2, 2'd2, 5'd0, 4'd0, 4'd2, 1'b0, 8'h00, 32'h80000000, 32'h0,        32'h0000FF28, 0,   3, `RM_SEL,       32'hFFFFFFFF, 1'b1);
        run_op("rs_zero",  2'd2, 2'd0, 5'd0, 4'd0, 4'd3, 1'b1, 8'h00, 32'h12345678, 32'h0,        32'h00000100, 0,   3, `RM_SEL,       32'h12345678, 1'b1);
        run_op("rs_ror4",  2'd2, 2'd3, 5'd0, 4'd0, 4'd12,1'b0, 8'h00, 32'h0000000F, 32'h0,        32'h00000004, 0,   3, `RM_SEL,       32'hF0000000, 1'b1);
        run_op("imm32",    2'd3, 2'd0, 5'd0, 4'd0, 4'd0, 1'b1, 8'h00, 32'h0,        32'hDEADBEEF, 32'h0,        5,   2, `IMMED_32_SEL, 32'hDEADBEEF, 1'b1);

        // Reset while a result is waiting in DONE.
        imm8 = 8'h12;
        bus.req_valid = 1'b1; bus.op_kind = 2'd0; bus.rotate_imm = 4'd1; bus.carry_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rstdone.valid_before", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstdone.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rstdone.req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rstdone.sel", {30'd0, shiftee_sel}, {30'd0, `RM_SEL});

        // Reset during the Rs fetch drops the request entirely.
        bus.req_valid = 1'b1; bus.op_kind = 2'd2; bus.rs_idx = 4'd4;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rstrs.rd_en", {31'd0, rs_rd_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstrs.rd_en_clr", {31'd0, rs_rd_en}, 32'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("rstrs.no_output", n, 0);
        check("rstrs.req_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
